control_pipe: RTL and testbench



---
 rtl/control_pkg.sv | 47 ++++
 rtl/ctrl_decode.sv | 51 +++++
 rtl/control_pipe.sv | 138 +++++++++++++
 tb/tb_control_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcodes, control bundle, forwarding selects and source-use helpers for control_pipe
package control_pkg;

  localparam logic [31:0] OP_ADD  = 32'h08;
  localparam logic [31:0] OP_MUL  = 32'h18;
  localparam logic [31:0] OP_ADDI = 32'h03;
  localparam logic [31:0] OP_SW   = 32'h19;
  localparam logic [31:0] OP_LW   = 32'h31;
  localparam logic [31:0] OP_JAL  = 32'h04;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_MUL = 4'b0010;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic [1:0] alu_src;
    logic [3:0] alu_op;
    logic       rb_select;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       pc_src;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  function automatic logic uses_rs1(input logic [31:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_ADDI) ||
           (op == OP_SW)  || (op == OP_LW);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control bundle decode; invalid or unknown opcodes give the all-zero bundle
module ctrl_decode
  import control_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] op,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    if (valid) begin
      case (op)
        OP_ADD: begin
          ctrl.alu_op     = ALU_ADD;
          ctrl.mem_to_reg = WB_ALU;
          ctrl.reg_write  = 1'b1;
        end
        OP_MUL: begin
          ctrl.alu_op     = ALU_MUL;
          ctrl.mem_to_reg = WB_ALU;
          ctrl.reg_write  = 1'b1;
        end
        OP_ADDI: begin
          ctrl.alu_src    = SRC_IMM;
          ctrl.mem_to_reg = WB_ALU;
          ctrl.reg_write  = 1'b1;
        end
        OP_SW: begin
          ctrl.alu_src    = SRC_IMM;
          ctrl.rb_select  = 1'b1;
          ctrl.mem_write  = 1'b1;
        end
        OP_LW: begin
          ctrl.alu_src    = SRC_IMM;
          ctrl.rb_select  = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = WB_MEM;
          ctrl.reg_write  = 1'b1;
        end
        OP_JAL: begin
          ctrl.mem_to_reg = WB_PC4;
          ctrl.reg_write  = 1'b1;
          ctrl.pc_src     = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - stage-aware RINSC control unit with hazard detection; CONTROL_PIPE_FORWARD_EN enables forwarding
module control_pipe
  import control_pkg::*;
#(
  parameter int OP_W   = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              mem_stall,
  output logic              stall,
  output logic              flush_if,
  output logic              id_pc_src,
  output logic [1:0]        ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic              ex_rb_select,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd
);

  function automatic logic hit(input logic use_src, input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rd, input logic wr);
    return use_src && (rs == rd) && (rd != '0) && wr;
  endfunction

  ctrl_t             id_ctrl, ex_ctrl;
  logic [REG_AW-1:0] ex_rd, mem_rd;
  logic [1:0]        mem_to_reg_m;
  logic              mem_reg_write;
  logic [31:0]       id_op_ext;
  logic              id_use1, id_use2, hit_ex, hazard;
  logic              unused_ex_pc_src;

  assign id_op_ext        = 32'(id_op);
  assign id_use1          = id_valid & uses_rs1(id_op_ext);
  assign id_use2          = id_valid & uses_rs2(id_op_ext);
  assign unused_ex_pc_src = ex_ctrl.pc_src;

  ctrl_decode u_decode (
    .valid (id_valid),
    .op    (id_op_ext),
    .ctrl  (id_ctrl)
  );

  assign hit_ex = hit(id_use1, id_rs1, ex_rd, ex_ctrl.reg_write) |
                  hit(id_use2, id_rs2, ex_rd, ex_ctrl.reg_write);

`ifdef CONTROL_PIPE_FORWARD_EN
  assign hazard = hit_ex & ex_ctrl.mem_read;
`else
  // Without forwarding, any producer still in EX or MEM must reach WB first.
  logic hit_mem;
  assign hit_mem = hit(id_use1, id_rs1, mem_rd, mem_reg_write) |
                   hit(id_use2, id_rs2, mem_rd, mem_reg_write);
  assign hazard  = hit_ex | hit_mem;
`endif

  assign stall     = ~reset & (mem_stall | hazard);
  assign id_pc_src = ~reset & ~mem_stall & ~hazard & id_ctrl.pc_src;
  assign flush_if  = id_pc_src;

  assign ex_alu_src   = ex_ctrl.alu_src;
  assign ex_alu_op    = ex_ctrl.alu_op;
  assign ex_rb_select = ex_ctrl.rb_select;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl       <= '0;
      ex_rd         <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_to_reg_m  <= '0;
      mem_reg_write <= 1'b0;
      mem_rd        <= '0;
      wb_mem_to_reg <= '0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
    end else if (!mem_stall) begin
      ex_ctrl       <= hazard ? ctrl_t'('0) : id_ctrl;
      ex_rd         <= hazard ? '0 : id_rd;
      mem_read      <= ex_ctrl.mem_read;
      mem_write     <= ex_ctrl.mem_write;
      mem_to_reg_m  <= ex_ctrl.mem_to_reg;
      mem_reg_write <= ex_ctrl.reg_write;
      mem_rd        <= ex_rd;
      wb_mem_to_reg <= mem_to_reg_m;
      wb_reg_write  <= mem_reg_write;
      wb_rd         <= mem_rd;
    end
  end

`ifdef CONTROL_PIPE_FORWARD_EN
  logic [REG_AW-1:0] ex_rs1, ex_rs2;
  logic              ex_use1, ex_use2;
  fwd_sel_t          fwd_a, fwd_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      ex_use1 <= 1'b0;
      ex_use2 <= 1'b0;
    end else if (!mem_stall) begin
      ex_rs1  <= hazard ? '0 : id_rs1;
      ex_rs2  <= hazard ? '0 : id_rs2;
      ex_use1 <= ~hazard & id_use1;
      ex_use2 <= ~hazard & id_use2;
    end
  end

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_a = FWD_RF;
    if (hit(ex_use1, ex_rs1, mem_rd, mem_reg_write))     fwd_a = FWD_MEM;
    else if (hit(ex_use1, ex_rs1, wb_rd, wb_reg_write))  fwd_a = FWD_WB;
    fwd_b = FWD_RF;
    if (hit(ex_use2, ex_rs2, mem_rd, mem_reg_write))     fwd_b = FWD_MEM;
    else if (hit(ex_use2, ex_rs2, wb_rd, wb_reg_write))  fwd_b = FWD_WB;
  end

  assign ex_fwd_a = fwd_a;
  assign ex_fwd_b = fwd_b;
`else
  assign ex_fwd_a = 2'b00;
  assign ex_fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - directed self-checking bench for control_pipe
module tb_control_pipe;

`ifdef CONTROL_PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [7:0] T_ADD = 8'h08, T_MUL = 8'h18, T_ADDI = 8'h03;
  localparam logic [7:0] T_SW = 8'h19, T_LW = 8'h31, T_JAL = 8'h04;

  logic       clk = 1'b0;
  logic       reset, id_valid, mem_stall;
  logic [7:0] id_op;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       stall, flush_if, id_pc_src, ex_rb_select, mem_read, mem_write, wb_reg_write;
  logic [1:0] ex_alu_src, ex_fwd_a, ex_fwd_b, wb_mem_to_reg;
  logic [3:0] ex_alu_op;
  logic [4:0] wb_rd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  control_pipe dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .mem_stall(mem_stall),
    .stall(stall), .flush_if(flush_if), .id_pc_src(id_pc_src),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rb_select(ex_rb_select),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mem_read(mem_read), .mem_write(mem_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd)
  );

  task automatic drive(input logic v, input logic [7:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = v; id_op = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
      adv();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_stall = 1'b0;
    drive(1'b1, T_LW, 5'd4, 5'd1, 5'd0);
    adv(); adv();
    total++; if ({stall, flush_if, id_pc_src, ex_alu_src, ex_alu_op, ex_rb_select, ex_fwd_a, ex_fwd_b,
                  mem_read, mem_write, wb_mem_to_reg, wb_reg_write, wb_rd} !== 24'd0)
      $display("FAIL reset_outputs: stall=%0b ex_alu_src=%0b mem_read=%0b wb_reg_write=%0b want all 0",
               stall, ex_alu_src, mem_read, wb_reg_write);
    else passed++;
    reset = 1'b0;
    drive(1'b1, T_ADD, 5'd3, 5'd1, 5'd2);
    total++; if ({stall, flush_if, ex_alu_src, ex_rb_select, mem_read, wb_reg_write} !== 7'd0)
      $display("FAIL after_reset_dropped: stall=%0b ex_alu_src=%0b ex_rb_select=%0b want 0",
               stall, ex_alu_src, ex_rb_select);
    else passed++;
    adv();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    total++; if ({ex_alu_op, ex_alu_src, ex_rb_select} !== 7'b0000_00_0)
      $display("FAIL add_ex: alu_op=%b alu_src=%b rb=%b want 0000/00/0", ex_alu_op, ex_alu_src, ex_rb_select);
    else passed++;
    adv(); adv();
    total++; if ({wb_reg_write, wb_rd, wb_mem_to_reg} !== {1'b1, 5'd3, 2'b01})
      $display("FAIL add_wb: reg_write=%0b rd=%0d mem_to_reg=%b want 1/3/01", wb_reg_write, wb_rd, wb_mem_to_reg);
    else passed++;
  endtask

  task automatic test_load_use();
    int cnt;
    drain();
    drive(1'b1, T_LW, 5'd5, 5'd1, 5'd0);
    adv();
    drive(1'b1, T_ADD, 5'd6, 5'd5, 5'd1);
    total++; if (stall !== 1'b1) $display("FAIL load_use_stall: got %0b want 1", stall);
    else passed++;
    cnt = 0;
    for (int i = 0; i < 6 && stall === 1'b1; i++) begin
      cnt++;
      adv();
      #1;
      if (cnt == 1) begin
        total++; if ({ex_alu_src, ex_rb_select, ex_alu_op, mem_read} !== {2'b00, 1'b0, 4'b0000, 1'b1})
          $display("FAIL load_use_bubble: ex_alu_src=%b rb=%b mem_read=%b want 00/0/1",
                   ex_alu_src, ex_rb_select, mem_read);
        else passed++;
      end
    end
    total++; if (cnt !== (FWD ? 1 : 2)) $display("FAIL load_use_stall_cycles: got %0d want %0d", cnt, FWD ? 1 : 2);
    else passed++;
    adv();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    total++; if ({ex_fwd_a, ex_fwd_b} !== {(FWD ? 2'b10 : 2'b00), 2'b00})
      $display("FAIL load_use_fwd: fwd_a=%b fwd_b=%b want %b/00", ex_fwd_a, ex_fwd_b, FWD ? 2'b10 : 2'b00);
    else passed++;
    adv(); adv();
    total++; if ({wb_reg_write, wb_rd, wb_mem_to_reg} !== {1'b1, 5'd6, 2'b01})
      $display("FAIL load_use_wb: reg_write=%0b rd=%0d m2r=%b want 1/6/01", wb_reg_write, wb_rd, wb_mem_to_reg);
    else passed++;
  endtask

  task automatic test_fwd_mem();
    int cnt;
    drain();
    drive(1'b1, T_ADDI, 5'd2, 5'd0, 5'd0);
    adv();
    drive(1'b1, T_SW, 5'd0, 5'd2, 5'd7);
    total++; if (stall !== (FWD ? 1'b0 : 1'b1)) $display("FAIL addi_sw_stall: got %0b want %0b", stall, !FWD);
    else passed++;
    cnt = 0;
    for (int i = 0; i < 6 && stall === 1'b1; i++) begin
      cnt++;
      adv();
      #1;
    end
    total++; if (cnt !== (FWD ? 0 : 2)) $display("FAIL addi_sw_stall_cycles: got %0d want %0d", cnt, FWD ? 0 : 2);
    else passed++;
    adv();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    total++; if ({ex_fwd_a, ex_fwd_b, ex_rb_select, ex_alu_src} !== {(FWD ? 2'b01 : 2'b00), 2'b00, 1'b1, 2'b01})
      $display("FAIL addi_sw_fwd: fwd_a=%b fwd_b=%b rb=%b alu_src=%b want %b/00/1/01",
               ex_fwd_a, ex_fwd_b, ex_rb_select, ex_alu_src, FWD ? 2'b01 : 2'b00);
    else passed++;
    drain();
    drive(1'b1, T_ADDI, 5'd0, 5'd1, 5'd0);
    adv();
    drive(1'b1, T_SW, 5'd0, 5'd0, 5'd0);
    total++; if (stall !== 1'b0) $display("FAIL x0_no_stall: got %0b want 0", stall);
    else passed++;
    adv();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    total++; if (ex_fwd_a !== 2'b00) $display("FAIL x0_fwd: got %b want 00", ex_fwd_a);
    else passed++;
  endtask

  task automatic test_jal();
    drain();
    drive(1'b1, T_JAL, 5'd1, 5'd0, 5'd0);
    total++; if ({id_pc_src, flush_if, stall} !== 3'b110)
      $display("FAIL jal_id: pc_src=%0b flush_if=%0b stall=%0b want 1/1/0", id_pc_src, flush_if, stall);
    else passed++;
    adv();
    drive(1'b0, T_ADD, 5'd9, 5'd0, 5'd0);
    total++; if ({id_pc_src, flush_if, ex_alu_src, ex_alu_op, ex_rb_select} !== 9'd0)
      $display("FAIL jal_flushed_slot: pc_src=%0b flush_if=%0b want 0/0", id_pc_src, flush_if);
    else passed++;
    adv(); adv();
    total++; if ({wb_reg_write, wb_rd, wb_mem_to_reg} !== {1'b1, 5'd1, 2'b10})
      $display("FAIL jal_wb: reg_write=%0b rd=%0d m2r=%b want 1/1/10", wb_reg_write, wb_rd, wb_mem_to_reg);
    else passed++;
    adv();
    total++; if (wb_reg_write !== 1'b0) $display("FAIL jal_bubble_wb: got %0b want 0", wb_reg_write);
    else passed++;
  endtask

  task automatic test_mem_stall();
    drain();
    drive(1'b1, T_LW, 5'd9, 5'd1, 5'd0);
    adv();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    adv();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(1'b1, T_JAL, 5'd1, 5'd0, 5'd0);
      else        drive(1'b1, T_MUL, 5'd4, 5'd3, 5'd3);
      total++; if ({stall, mem_read, wb_reg_write, ex_alu_op, flush_if, id_pc_src} !== {1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0})
        $display("FAIL mem_stall_hold_%0d: stall=%0b mem_read=%0b wb_rw=%0b alu_op=%b flush=%0b pc_src=%0b want 1/1/0/0000/0/0",
                 i, stall, mem_read, wb_reg_write, ex_alu_op, flush_if, id_pc_src);
      else passed++;
      adv();
    end
    mem_stall = 1'b0;
    drive(1'b1, T_MUL, 5'd4, 5'd3, 5'd3);
    total++; if (stall !== 1'b0) $display("FAIL mem_stall_release: got %0b want 0", stall);
    else passed++;
    adv();
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    total++; if ({ex_alu_op, mem_read, wb_reg_write, wb_rd, wb_mem_to_reg} !== {4'b0010, 1'b0, 1'b1, 5'd9, 2'b00})
      $display("FAIL mem_stall_resume: alu_op=%b mem_read=%0b wb_rw=%0b wb_rd=%0d m2r=%b want 0010/0/1/9/00",
               ex_alu_op, mem_read, wb_reg_write, wb_rd, wb_mem_to_reg);
    else passed++;
  endtask

  task automatic test_nop();
    drain();
    drive(1'b1, 8'hFF, 5'd7, 5'd1, 5'd2);
    adv();
    drive(1'b0, T_SW, 5'd8, 5'd1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      total++; if ({stall, wb_reg_write, mem_write, mem_read, ex_alu_src, ex_rb_select} !== 7'd0)
        $display("FAIL nop_bubble_%0d: stall=%0b wb_rw=%0b mem_write=%0b ex_alu_src=%b want 0",
                 i, stall, wb_reg_write, mem_write, ex_alu_src);
      else passed++;
      adv();
      drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
    end
  endtask

  initial begin
    reset = 1'b1; mem_stall = 1'b0;
    id_valid = 1'b0; id_op = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    test_reset();
    test_load_use();
    test_fwd_mem();
    test_jal();
    test_mem_stall();
    test_nop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
